// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-byte holding register feeding a framed shift-out FSM.
// Optional parity support is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [DIV_W-1:0] divisor_i,
  input  logic [7:0]       lcr_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             txd_o,
  output logic             thre_o,
  output logic             temt_o,
  output logic             thre_pulse_o
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int LCR_W = 4;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
  localparam int LCR_W = 3;
`endif

  state_e             state_q, state_d;
  logic [7:0]         thr_q, thr_d;
  logic               thr_full_q, thr_full_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic [LCR_W-1:0]   lcr_q, lcr_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               txd_q, txd_d;
  logic               pulse_q, pulse_d;
  logic               par_q, par_d;

  logic               accept;
  logic               load;
  logic               bit_adv;
  logic [DIV_W-1:0]   div_last;
  logic [2:0]         n_last;
  logic               unused_lcr;

`ifdef UART_TX_PARITY_EN
  assign unused_lcr = lcr_i[7];

  // Parity covers only the bits inside the configured word length.
  function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] wl,
                                       input logic eps, input logic stick);
    logic [7:0] mask;
    case (wl)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    if (stick) return !eps;
    return eps ? ^(d & mask) : ~^(d & mask);
  endfunction
`else
  assign unused_lcr = ^{lcr_i[7], lcr_i[5:3]};
`endif

  assign accept   = tx_valid_i && !thr_full_q;
  assign div_last = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  assign bit_adv  = (presc_q == div_last) && (tick_q == TICK_LAST);
  assign n_last   = 3'd4 + 3'(lcr_q[1:0]);

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    lcr_d      = lcr_q;
    div_d      = div_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    par_d      = par_q;
    pulse_d    = 1'b0;
    load       = 1'b0;

    if (state_q != IDLE) begin
      if (presc_q == div_last) begin
        presc_d = '0;
        tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end

    case (state_q)
      IDLE:  if (thr_full_q) load = 1'b1;
      START: if (bit_adv) state_d = DATA;
      DATA: begin
        if (bit_adv) begin
          if (bit_cnt_q == n_last) begin
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = lcr_q[3] ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_adv) state_d = STOP;
`endif
      STOP: begin
        if (bit_adv) begin
          if (stop_cnt_q == lcr_q[2]) begin
            // Back-to-back frames: reload straight into START with no idle bit.
            if (thr_full_q) load = 1'b1;
            else            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = START;
      shift_d    = thr_q;
      lcr_d      = lcr_i[LCR_W-1:0];
      div_d      = divisor_i;
      presc_d    = '0;
      tick_d     = '0;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      thr_full_d = 1'b0;
      pulse_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d      = calc_parity(thr_q, lcr_i[1:0], lcr_i[4], lcr_i[5]);
`else
      par_d      = 1'b0;
`endif
    end

    if (accept) begin
      thr_d      = tx_data_i;
      thr_full_d = 1'b1;
    end

    // Line level is derived from the next state so it lines up with the state register.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
    if (lcr_i[6]) txd_d = 1'b0;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= IDLE;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      lcr_q      <= '0;
      div_q      <= '0;
      presc_q    <= '0;
      tick_q     <= '0;
      txd_q      <= 1'b1;
      pulse_q    <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      lcr_q      <= lcr_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      txd_q      <= txd_d;
      pulse_q    <= pulse_d;
      par_q      <= par_d;
    end
  end

  assign tx_ready_o   = !thr_full_q;
  assign thre_o       = !thr_full_q;
  assign temt_o       = !thr_full_q && (state_q == IDLE);
  assign txd_o        = txd_q;
  assign thre_pulse_o = pulse_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed plus randomized frames
// compared against a per-bit line-level model built from the framing rules.
module tb_uart_tx_serializer;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [15:0] divisor_i = 16'd1;
  logic [7:0]  lcr_i = 8'h03;
  logic [7:0]  tx_data_i = 8'h00;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o, txd_o, thre_o, temt_o, thre_pulse_o;

  always #5 CLK_I = ~CLK_I;

  uart_tx_serializer #(.DIV_W(16), .OVERSAMPLE(OS)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .divisor_i(divisor_i), .lcr_i(lcr_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .txd_o(txd_o), .thre_o(thre_o), .temt_o(temt_o), .thre_pulse_o(thre_pulse_o)
  );

  int checks = 0;
  int failures = 0;
  bit lv_q[$];
  logic bit9;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line levels of one character, one entry per bit period.
  task automatic add_frame(input logic [7:0] d, input logic [7:0] lcr);
    int n;
    int ones;
    bit p;
    n = 5 + int'(lcr[1:0]);
    ones = 0;
    lv_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      lv_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (PAR_EN && lcr[3]) begin
      if (lcr[5])      p = !lcr[4];
      else if (lcr[4]) p = (ones % 2) == 1;
      else             p = (ones % 2) == 0;
      lv_q.push_back(p);
    end
    lv_q.push_back(1'b1);
    if (lcr[2]) lv_q.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] d0, input logic [7:0] lcr, input logic [15:0] dv,
                      input bit two, input logic [7:0] d1, input bit scramble, input string tag);
    int waited, len, pulses, m, j, nb;
    logic brk;
    waited = 0;
    while (!temt_o && waited < 5000) begin
      @(negedge CLK_I);
      waited++;
    end
    check({tag, "_idle"}, temt_o, 1);
    lv_q.delete();
    add_frame(d0, lcr);
    if (two) add_frame(d1, lcr);
    nb = lv_q.size();
    len = OS * ((dv == 0) ? 1 : int'(dv));
    brk = lcr[6];
    pulses = 0;
    j = 0;
    bit9 = 1'bx;
    lcr_i = lcr; divisor_i = dv; tx_data_i = d0; tx_valid_i = 1'b1;
    @(negedge CLK_I);
    if (two) tx_data_i = d1;
    else     tx_valid_i = 1'b0;
    for (int b = 0; b < nb; b++) begin
      m = 0;
      for (int c = 0; c < len; c++) begin
        @(negedge CLK_I);
        j++;
        if (thre_pulse_o) pulses++;
        if (two && j == 1) check({tag, "_ready_reopen"}, tx_ready_o, 1);
        if (two && j == 2) begin
          check({tag, "_ready_taken"}, tx_ready_o, 0);
          tx_valid_i = 1'b0;
        end
        if (scramble && j == 3) begin
          lcr_i = {1'b0, brk, 6'($urandom)};
          divisor_i = 16'($urandom_range(0, 5));
        end
        if (b == 9 && c == len / 2) bit9 = txd_o;
        if (txd_o === (lv_q[b] && !brk)) m++;
        if (b == nb - 1 && c == len - 1) check({tag, "_temt_busy"}, temt_o, 0);
      end
      check($sformatf("%s_bit%0d", tag, b), m, len);
    end
    lcr_i[6] = 1'b0;
    @(negedge CLK_I);
    check({tag, "_txd_idle"}, txd_o, 1);
    check({tag, "_temt_done"}, temt_o, 1);
    check({tag, "_pulses"}, pulses, two ? 2 : 1);
  endtask

  task automatic reset_mid_frame();
    int waited, m;
    waited = 0;
    while (!temt_o && waited < 5000) begin
      @(negedge CLK_I);
      waited++;
    end
    check("rst_idle", temt_o, 1);
    lcr_i = 8'h03; divisor_i = 16'd2; tx_data_i = 8'h81; tx_valid_i = 1'b1;
    @(negedge CLK_I);
    tx_data_i = 8'h7E;
    for (int i = 0; i < 2 * OS * 2 + 40; i++) @(negedge CLK_I);
    tx_valid_i = 1'b0;
    check("rst_thr_full_pre", tx_ready_o, 0);
    RST_I = 1'b0;
    #1;
    check("rst_txd_async", txd_o, 1);
    check("rst_ready_async", tx_ready_o, 1);
    check("rst_temt_async", temt_o, 1);
    @(negedge CLK_I);
    RST_I = 1'b1;
    m = 0;
    for (int i = 0; i < 12 * OS * 2 + 10; i++) begin
      @(negedge CLK_I);
      if (txd_o === 1'b1 && temt_o === 1'b1) m++;
    end
    check("rst_no_frame", m, 12 * OS * 2 + 10);
  endtask

  initial begin
    #2 RST_I = 1'b0;
    #1;
    check("reset_txd", txd_o, 1);
    check("reset_ready", tx_ready_o, 1);
    check("reset_thre", thre_o, 1);
    check("reset_temt", temt_o, 1);
    check("reset_pulse", thre_pulse_o, 0);
    @(negedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);

    send(8'h55, 8'h03, 16'd1, 1'b0, 8'h00, 1'b0, "t55");
    send(8'hA5, 8'h03, 16'd1, 1'b1, 8'h3C, 1'b0, "b2b");

    send(8'h07, 8'h1B, 16'd1, 1'b0, 8'h00, 1'b0, "p_even");
    check("p_even_val", bit9, 1);
    send(8'h07, 8'h0B, 16'd1, 1'b0, 8'h00, 1'b0, "p_odd");
    check("p_odd_val", bit9, PAR_EN ? 0 : 1);
    send(8'h07, 8'h3B, 16'd1, 1'b0, 8'h00, 1'b0, "p_stick");
    check("p_stick_val", bit9, PAR_EN ? 0 : 1);

    send(8'hFF, 8'h04, 16'd3, 1'b0, 8'h00, 1'b0, "f5n2");
    send(8'h5A, 8'h43, 16'd2, 1'b0, 8'h00, 1'b0, "brk");
    send(8'h96, 8'h07, 16'd0, 1'b0, 8'h00, 1'b0, "div0");

    for (int i = 0; i < 16; i++) begin
      logic [7:0] rl;
      rl = {1'b0, ($urandom_range(0, 7) == 0), 6'($urandom)};
      if (i % 2 == 0)
        send(8'($urandom), rl, 16'($urandom_range(0, 3)), 1'b0, 8'h00, 1'b1,
             $sformatf("rnd%0d", i));
      else
        send(8'($urandom), {1'b0, 1'b0, rl[5:0]}, 16'($urandom_range(0, 2)), 1'b1,
             8'($urandom), 1'b0, $sformatf("rnd%0d", i));
    end

    reset_mid_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side serializer that sits directly downstream of the 8250-compatible register block on the Wishbone UART. It accepts bytes from the register block's transmit path over a valid/ready handshake and holds one byte in a holding register (THR). It then shifts that byte out on the serial line as a framed character: start bit, 5–8 data bits LSB first, optional parity bit, 1 or 2 stop bits. Framing follows the LCR and divisor values driven by the register block, and the block reports THRE/TEMT status back for LSR and IIR generation.

## Interface
Parameters:
- DIV_W, 16, width of baud divisor input.
- OVERSAMPLE, 16, clocks-per-divisor-tick multiplier; bit period = OVERSAMPLE × divisor clocks.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- divisor_i  in  DIV_W  baud divisor {DLM,DLL}; value 0 treated as 1.
- lcr_i  in  8  line control:
  - [1:0] word length 5/6/7/8.
  - [2] stop bits (0 = 1, 1 = 2).
  - [3] PEN, [4] EPS, [5] stick parity.
  - [6] break.
- tx_data_i  in  8  byte to transmit; bits above word length ignored.
- tx_valid_i  in  1  byte offered.
- tx_ready_o  out  1  THR empty, can accept.
- txd_o  out  1  serial output, idle high.
- thre_o  out  1  holding register empty (LSR[5]).
- temt_o  out  1  holding and shift register both empty (LSR[6]).
- thre_pulse_o  out  1  one-cycle pulse when THR transitions full→empty (THRE interrupt source).

## Operation
- Handshake: a byte is accepted on a rising edge with tx_valid_i && tx_ready_o, and loads into THR. tx_ready_o = thre_o = !thr_full.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when THR is full. THR moves into the shift register on the same edge, and thr_full clears.
  - START→DATA after 1 bit period.
  - DATA→PARITY after N = 5 + lcr[1:0] bits if PEN, else DATA→STOP.
  - PARITY→STOP after 1 bit period.
  - STOP lasts 1 or 2 bit periods. At the end of STOP, go to START if THR is full (no idle gap), else IDLE.
- lcr_i and divisor_i are latched at the IDLE→START or STOP→START transition. Changes mid-frame affect only the next frame.
- Bit timing:
  - Prescaler counts 0..div-1 and emits a tick each wrap.
  - Tick counter counts 0..OVERSAMPLE-1.
  - Bit advances on the tick where the tick counter = OVERSAMPLE-1.
  - Both counters reset to 0 on entering START.
- Parity is computed over the N data bits only:
  - PEN=1, stick=0: EPS=1 gives even parity (bit = XOR of data bits); EPS=0 gives odd parity (bit = inverse XOR).
  - Stick=1: parity bit = !EPS.
- Break: while lcr_i[6]=1, txd_o is forced 0 combinationally-registered (next edge). The FSM keeps running and frames complete internally.
- temt_o = thre_o && state==IDLE.

## Timing
- Reset values:
  - txd_o=1, tx_ready_o=1, thre_o=1, temt_o=1, thre_pulse_o=0.
  - state=IDLE, THR empty, counters 0.
- Reset mid-frame aborts immediately: txd_o=1 asynchronously, and the pending THR byte is discarded.
- Latency: byte accepted at edge k → txd_o=0 (start bit) from edge k+1, provided state was IDLE.
- Frame length = (1 + N + PEN + stop) × OVERSAMPLE × div clocks.
- thre_pulse_o is high for the one cycle after THR empties. There is no pulse when acceptance and the THR→shift move coincide on the same edge while the FSM is in the STOP→START handover; THR then stays full.
- When the end-of-STOP edge and a new acceptance coincide with THR empty, the new byte enters THR. START follows on the next edge: 1-cycle idle-high gap, permitted.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and parity generation are present; lcr_i[5:3] are honoured.
- Not defined: the PARITY state is removed, lcr_i[5:3] are ignored, and no parity bit is ever sent. The frame length formula uses PEN=0.

## Test plan
- Reset with divisor=1, 8N1 (lcr=0x03), send 0x55:
  - txd_o low 16 clocks, then bits 1,0,1,0,1,0,1,0 for 16 clocks each, then high 16 clocks.
  - temt_o returns 1 exactly 161 clocks after acceptance.
- Back-to-back 0xA5, 0x3C with valid held:
  - second byte accepted the cycle after the first frame starts.
  - no idle-high gap between the first stop bit and the second start bit.
  - thre_pulse_o pulses once per THR empty.
- Parity (macro on), lcr=0x1B (8E1), byte 0x07: parity bit = 1. Then lcr=0x0B (8O1): parity bit = 0. Then lcr=0x3B (stick, EPS=1): parity bit = 0.
- lcr=0x04 (5N2), divisor=3, byte 0xFF:
  - txd_o shows 5 data bits of 48 clocks each and 96 clocks of stop.
  - bits 7:5 never appear.
- Assert RST_I low in the middle of DATA with THR full: txd_o=1 immediately, tx_ready_o=1, and no further frame after release.
- lcr[6]=1 during a frame: txd_o=0 throughout. On clearing, txd_o=1 and temt_o=1 once the frame's internal timing completes.
